radix_bist_ctrl: RTL and testbench

- Self-test controller for the 4x4 radix multiplier (clk, reset, x[3:0], y[3:0] -> out[7:0]).
- In test mode it:
  - drives the multiplier inputs from an 8-bit LFSR;
  - compacts the multiplier outputs in an 8-bit MISR;
  - compares the final signature with a golden value.
- In functional mode it passes functional operands straight through.
- Sits between the system operand source and the multiplier. Owns the multiplier's reset during test.

---
 rtl/bist_pkg.sv | 25 ++
 rtl/radix_bist_ctrl_if.sv | 36 +++
 rtl/bist_lfsr8.sv | 41 ++++
 rtl/radix_bist_ctrl.sv | 167 ++++++++++++++++
 tb/tb_radix_bist_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared types and constants for the radix multiplier BIST
//               controller (state encoding, LFSR/MISR taps, signature width).
// Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    localparam int SIG_W = 8;

    // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
    localparam logic [SIG_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/radix_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : radix_bist_ctrl_if
// Description : Operand/product and status bundle between the system, the
//               BIST controller and the multiplier under test.
// Revision    : 1.0 - initial release
// ============================================================================
interface radix_bist_ctrl_if;
    import bist_pkg::*;

    logic             start;
    logic [3:0]       func_x;
    logic [3:0]       func_y;
    logic [SIG_W-1:0] cut_out;
    logic [3:0]       cut_x;
    logic [3:0]       cut_y;
    logic             cut_reset;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;

    // Controller side
    modport slave (
        input  start, func_x, func_y, cut_out,
        output cut_x, cut_y, cut_reset, busy, done, pass, signature
    );

    // System / multiplier side
    modport master (
        output start, func_x, func_y, cut_out,
        input  cut_x, cut_y, cut_reset, busy, done, pass, signature
    );

endinterface
`default_nettype wire

// File: rtl/bist_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : bist_lfsr8
// Description : Fibonacci shift register with synchronous load of a fixed
//               seed, step enable and a parallel XOR input. With data_i tied
//               to zero it is a pattern generator; fed with a response word
//               it acts as a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr8 #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic             enable_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             w_fb;

    assign w_fb = ^(q_q & TAPS);
    assign q_d  = {q_q[WIDTH-2:0], w_fb} ^ data_i;
    assign q_o  = q_q;

    // Seed on reset or load, otherwise step when enabled
    always_ff @(posedge clk) begin
        if (reset || load_i) begin
            q_q <= SEED;
        end else if (enable_i) begin
            q_q <= q_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/radix_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : radix_bist_ctrl
// Description : Self-test controller for the 4x4 radix multiplier. Applies
//               LFSR patterns, compacts products in a MISR and compares the
//               final signature with a golden value; passes functional
//               operands straight through when not testing.
// Revision    : 1.0 - initial release
// ============================================================================
module radix_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               N_PATTERNS = 255,
    parameter int               CUT_LAT    = 1,
    parameter logic [SIG_W-1:0] LFSR_SEED  = 8'hA5,
    parameter logic [SIG_W-1:0] MISR_SEED  = 8'h00,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 8'h00
) (
    input  wire logic          clk,
    input  wire logic          reset,
    radix_bist_ctrl_if.slave   bus
);

    localparam logic [7:0] PAT_LAST   = 8'(N_PATTERNS - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(CUT_LAT - 1);

    state_t           state_q, state_d;
    logic [7:0]       pat_cnt_q, pat_cnt_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic             pass_q, pass_d;
    logic [CUT_LAT-1:0] vpipe_q;

    logic             w_init;
    logic             w_run;
    logic             w_misr_en;
    logic [SIG_W-1:0] w_pat;
    logic [SIG_W-1:0] w_sig;

    assign w_init    = (state_q == ST_INIT);
    assign w_run     = (state_q == ST_RUN);
    assign w_misr_en = vpipe_q[CUT_LAT-1];

    bist_lfsr8 #(
        .WIDTH (SIG_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_pat_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (w_init),
        .enable_i (w_run),
        .data_i   ({SIG_W{1'b0}}),
        .q_o      (w_pat)
    );

    bist_lfsr8 #(
        .WIDTH (SIG_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (w_init),
        .enable_i (w_misr_en),
        .data_i   (bus.cut_out),
        .q_o      (w_sig)
    );

    // Valid pipe tracks which cycles carry a product of an applied pattern
    if (CUT_LAT == 1) begin : g_vpipe_1
        // Single-stage valid flag
        always_ff @(posedge clk) begin
            if (reset || w_init) begin
                vpipe_q <= '0;
            end else begin
                vpipe_q <= w_run;
            end
        end
    end else begin : g_vpipe_n
        // Multi-stage valid shift register
        always_ff @(posedge clk) begin
            if (reset || w_init) begin
                vpipe_q <= '0;
            end else begin
                vpipe_q <= {vpipe_q[CUT_LAT-2:0], w_run};
            end
        end
    end

    // State, counters and result flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pat_cnt_q   <= '0;
            drain_cnt_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_cnt_q   <= pat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state, counter and pass-flag logic
    always_comb begin
        state_d     = state_q;
        pat_cnt_d   = pat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_INIT;
            end
            ST_INIT: begin
                pat_cnt_d   = '0;
                drain_cnt_d = '0;
                pass_d      = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                pat_cnt_d = pat_cnt_q + 8'd1;
                if (pat_cnt_q == PAT_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_COMPARE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            ST_COMPARE: begin
                pass_d  = (w_sig == GOLDEN_SIG);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) state_d = ST_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand mux: patterns in RUN, quiet zeros elsewhere in test, functional otherwise
    always_comb begin
        bus.cut_x = 4'h0;
        bus.cut_y = 4'h0;
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            bus.cut_x = bus.func_x;
            bus.cut_y = bus.func_y;
        end else if (state_q == ST_RUN) begin
            bus.cut_x = w_pat[7:4];
            bus.cut_y = w_pat[3:0];
        end
    end

    assign bus.cut_reset = reset | w_init;
    assign bus.busy      = (state_q == ST_INIT) || (state_q == ST_RUN) ||
                           (state_q == ST_DRAIN) || (state_q == ST_COMPARE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = w_sig;

endmodule
`default_nettype wire

// File: tb/tb_radix_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix_bist_ctrl
// Description : Self-checking bench for radix_bist_ctrl. Two controllers
//               (4 patterns / latency 1, 255 patterns / latency 2) drive
//               behavioural multipliers; a run-phase model predicts every
//               output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix_bist_ctrl;

    localparam int N0 = 4;
    localparam int L0 = 1;
    localparam int N1 = 255;
    localparam int L1 = 2;

    // Signature after nupd compactions of the seed pattern sequence
    function automatic logic [7:0] misr_after(input int nupd, input logic [7:0] mask);
        logic [7:0] lf, m, a, b, p;
        lf = 8'hA5;
        m  = 8'h00;
        for (int j = 0; j < nupd; j++) begin
            a  = {4'h0, lf[7:4]};
            b  = {4'h0, lf[3:0]};
            p  = (a * b) & ~mask;
            m  = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ p;
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end
        return m;
    endfunction

    // i-th pattern word applied in RUN
    function automatic logic [7:0] pat_nth(input int i);
        logic [7:0] lf;
        lf = 8'hA5;
        for (int j = 0; j < i; j++) lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        return lf;
    endfunction

    localparam logic [7:0] GOLD0 = misr_after(N0, 8'h00);
    localparam logic [7:0] GOLD1 = misr_after(N1, 8'h00);

    logic clk;
    logic reset;
    logic chk_en;
    int   checks;
    int   failures;

    radix_bist_ctrl_if if0 ();
    radix_bist_ctrl_if if1 ();

    radix_bist_ctrl #(.N_PATTERNS(N0), .CUT_LAT(L0), .LFSR_SEED(8'hA5),
                      .MISR_SEED(8'h00), .GOLDEN_SIG(GOLD0))
        u_small (.clk(clk), .reset(reset), .bus(if0.slave));

    radix_bist_ctrl #(.N_PATTERNS(N1), .CUT_LAT(L1), .LFSR_SEED(8'hA5),
                      .MISR_SEED(8'h00), .GOLDEN_SIG(GOLD1))
        u_big (.clk(clk), .reset(reset), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural multipliers (registered, cleared by cut_reset) with stuck-at-0 masks
    logic [7:0] mul0, p1, mul1;
    logic [7:0] fmask [2];
    always @(posedge clk) begin
        if (if0.cut_reset) mul0 <= 8'h00;
        else               mul0 <= 8'(if0.cut_x) * 8'(if0.cut_y);
        if (if1.cut_reset) begin
            p1   <= 8'h00;
            mul1 <= 8'h00;
        end else begin
            p1   <= 8'(if1.cut_x) * 8'(if1.cut_y);
            mul1 <= p1;
        end
    end
    assign if0.cut_out = mul0 & ~fmask[0];
    assign if1.cut_out = mul1 & ~fmask[1];

    // Run-phase model: k = cycles since start accepted (1 = first busy cycle), 0 = not running
    int         k_m      [2];
    logic       done_m   [2];
    logic       pass_m   [2];
    logic [7:0] sig_m    [2];
    logic [7:0] mask_run [2];

    function automatic int nof(input int d); return (d == 0) ? N0 : N1; endfunction
    function automatic int lof(input int d); return (d == 0) ? L0 : L1; endfunction
    function automatic logic [7:0] gof(input int d); return (d == 0) ? GOLD0 : GOLD1; endfunction

    always @(posedge clk) begin
        logic st;
        for (int d = 0; d < 2; d++) begin
            st = (d == 0) ? if0.start : if1.start;
            if (reset) begin
                k_m[d] = 0; done_m[d] = 1'b0; pass_m[d] = 1'b0; sig_m[d] = 8'h00;
            end else if (k_m[d] == 0) begin
                if (st) begin
                    k_m[d] = 1;
                    mask_run[d] = fmask[d];
                end
            end else if (k_m[d] == nof(d) + lof(d) + 2) begin
                k_m[d]    = 0;
                done_m[d] = 1'b1;
                sig_m[d]  = misr_after(nof(d), mask_run[d]);
                pass_m[d] = (sig_m[d] == gof(d));
            end else begin
                k_m[d] = k_m[d] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic b, input logic dn, input logic p,
                           input logic cr, input logic [3:0] cx, input logic [3:0] cy,
                           input logic [7:0] sg, input logic [3:0] fx, input logic [3:0] fy);
        int k, n, l, nu;
        logic [7:0] pt, es;
        k = k_m[d]; n = nof(d); l = lof(d);
        chk($sformatf("busy%0d", d), 32'(b), 32'(k > 0));
        chk($sformatf("done%0d", d), 32'(dn), 32'(k == 0 && done_m[d]));
        chk($sformatf("pass%0d", d), 32'(p), (k <= 1) ? 32'(pass_m[d]) : 32'd0);
        chk($sformatf("cut_reset%0d", d), 32'(cr), 32'(reset || k == 1));
        if (k <= 1) begin
            es = sig_m[d];
        end else begin
            nu = k - 2 - l;
            if (nu < 0) nu = 0;
            if (nu > n) nu = n;
            es = misr_after(nu, mask_run[d]);
        end
        chk($sformatf("signature%0d", d), 32'(sg), 32'(es));
        if (k == 0) begin
            chk($sformatf("func_xy%0d", d), {24'h0, cx, cy}, {24'h0, fx, fy});
        end else if (k >= 2 && k <= n + 1) begin
            pt = pat_nth(k - 2);
            chk($sformatf("pattern_xy%0d", d), {24'h0, cx, cy}, {24'h0, pt});
        end else if (k >= n + 2 && k <= n + l + 1) begin
            chk($sformatf("drain_xy%0d", d), {24'h0, cx, cy}, 32'h0);
        end
    endtask

    // Compare both controllers against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, if0.busy, if0.done, if0.pass, if0.cut_reset, if0.cut_x, if0.cut_y,
                    if0.signature, if0.func_x, if0.func_y);
            cmp_dut(1, if1.busy, if1.done, if1.pass, if1.cut_reset, if1.cut_x, if1.cut_y,
                    if1.signature, if1.func_x, if1.func_y);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input int bound);
        int c;
        c = 0;
        while (!((d == 0) ? if0.done : if1.done) && c < bound) begin
            tick();
            c++;
        end
        chk($sformatf("wait_done%0d", d), 32'((d == 0) ? if0.done : if1.done), 32'd1);
    endtask

    logic [3:0] ex_x [4];
    logic [3:0] ex_y [4];
    int cyc, nbusy, nrst, nen;

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        ex_x = '{4'hA, 4'h4, 4'h9, 4'h2};
        ex_y = '{4'h5, 4'hA, 4'h5, 4'hA};
        fmask[0] = 8'h00; fmask[1] = 8'h00;
        reset = 1'b1;
        if0.start = 1'b0; if0.func_x = 4'h0; if0.func_y = 4'h0;
        if1.start = 1'b0; if1.func_x = 4'h0; if1.func_y = 4'h0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_busy", 32'(if0.busy), 32'd0);
        chk("reset_done", 32'(if0.done), 32'd0);
        chk("reset_pass", 32'(if0.pass), 32'd0);
        chk("reset_sig", 32'(if0.signature), 32'h00);

        // Functional pass-through in IDLE
        if0.func_x = 4'd7; if0.func_y = 4'd3;
        #1;
        chk("idle_cut_x", 32'(if0.cut_x), 32'd7);
        chk("idle_cut_y", 32'(if0.cut_y), 32'd3);
        tick();
        chk("idle_product", 32'(if0.cut_out), 32'h15);

        // Directed 4-pattern run with an ignored start mid-run
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        cyc = 0; nbusy = 0; nrst = 0; nen = 0;
        while (!if0.done && cyc < 20) begin
            if (if0.busy) nbusy++;
            if (if0.cut_reset) nrst++;
            if (u_small.w_misr_en) nen++;
            if (cyc >= 1 && cyc <= 4) begin
                chk($sformatf("lit_x%0d", cyc), 32'(if0.cut_x), 32'(ex_x[cyc-1]));
                chk($sformatf("lit_y%0d", cyc), 32'(if0.cut_y), 32'(ex_y[cyc-1]));
            end
            if (cyc == 2) if0.start = 1'b1;
            tick();
            if0.start = 1'b0;
            cyc++;
        end
        chk("done_latency", 32'(cyc), 32'd7);
        chk("busy_cycles", 32'(nbusy), 32'd7);
        chk("cut_reset_cycles", 32'(nrst), 32'd1);
        chk("misr_updates", 32'(nen), 32'd4);
        chk("small_sig", 32'(if0.signature), 32'h7D);
        chk("small_pass", 32'(if0.pass), 32'd1);

        // Functional pass-through in DONE
        if0.func_x = 4'd7; if0.func_y = 4'd3;
        #1;
        chk("done_cut_xy", {24'h0, if0.cut_x, if0.cut_y}, 32'h73);
        tick();
        chk("done_product", 32'(if0.cut_out), 32'h15);

        // Re-run from DONE gives the same signature
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        wait_done(0, 30);
        chk("rerun_sig", 32'(if0.signature), 32'h7D);

        // Full-length run, then with product bit 0 stuck at 0
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        wait_done(1, 400);
        chk("big_pass", 32'(if1.pass), 32'd1);
        fmask[1] = 8'h01;
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        wait_done(1, 400);
        chk("fault_pass", 32'(if1.pass), 32'd0);
        chk("fault_sig_differs", 32'(if1.signature != GOLD1), 32'd1);
        fmask[1] = 8'h00;

        // Reset mid-RUN aborts cleanly
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_busy", 32'(if0.busy), 32'd0);
        chk("abort_done", 32'(if0.done), 32'd0);
        chk("abort_sig", 32'(if0.signature), 32'h00);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if0.func_x = 4'($urandom); if0.func_y = 4'($urandom);
            if1.func_x = 4'($urandom); if1.func_y = 4'($urandom);
            if (k_m[0] == 0 && $urandom_range(0, 7) == 0)
                fmask[0] = ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            if0.start = ($urandom_range(0, 5) == 0);
            if1.start = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        if0.start = 1'b0; if1.start = 1'b0; reset = 1'b0;
        for (int i = 0; i < 300; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
